alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, registered ALU with valid/ready handshakes on input and output.
//   Extends the 4-op combinational ALU to 8 ops: adds XOR, shifts, signed overflow
//   and a multi-cycle shift-add unsigned multiply with a double-width product.
//   Sits between an operand producer and a result consumer; one operation in flight.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; power of two, >= 4
// PORTS
//   clk        in   1        clock, all state updates on rising edge
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   1        a/b/op valid
//   in_ready   out  1        block accepts an op this cycle
//   a          in   WIDTH    operand A (unsigned; signed view used for v only)
//   b          in   WIDTH    operand B / shift amount
//   op         in   3        000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SHL,110 SHR,111 MUL
//   out_valid  out  1        result registers valid
//   out_ready  in   1        consumer takes result this cycle
//   y          out  WIDTH    result (MUL: low half of product)
//   y_hi       out  WIDTH    MUL high half; 0 for all other ops
//   z,n,c      out  1 each   zero, negative, carry flags
//   bflag      out  1        borrow flag (SUB: a < b unsigned)
//   v          out  1        signed overflow (ADD/SUB only)
// BEHAVIOUR
//   - Accept = in_valid & in_ready; a/b/op captured on accept edge.
//   - FSM: IDLE -> (accept, op!=MUL) DONE; IDLE -> (accept, MUL) EXEC;
//     EXEC: WIDTH iterations, 1 bit of b per cycle (LSB first), then DONE;
//     DONE -> (out_ready & accept) DONE/EXEC per new op; (out_ready & !in_valid) IDLE.
//   - in_ready = !rst & (IDLE | (DONE & out_ready)); 0 throughout EXEC.
//   - out_valid = (state==DONE). Latency: non-MUL out_valid the cycle after accept;
//     MUL out_valid WIDTH+1 cycles after accept. Back-to-back non-MUL: 1 op/cycle.
//   - While out_valid & !out_ready: y, y_hi, all flags held stable.
//   - ADD: {c,y}=a+b; v = a[W-1]==b[W-1] && y[W-1]!=a[W-1].
//   - SUB: y=a-b mod 2^W; bflag=(a<b); v = a[W-1]!=b[W-1] && y[W-1]!=a[W-1]; c=0.
//   - SHL/SHR logical, amt=b (full value). amt>=WIDTH -> y=0.
//     SHL c=a[WIDTH-amt] for 1<=amt<=WIDTH, SHR c=a[amt-1] for 1<=amt<=WIDTH, else c=0.
//   - MUL: {y_hi,y}=a*b unsigned; c=v=bflag=0.
//   - z = (y==0) for non-MUL, ({y_hi,y}==0) for MUL; n = MSB of y (MUL: y_hi[W-1]).
//   - Flags not defined above are 0 for that op; y_hi=0 for non-MUL.
//   - Reset: state IDLE; out_valid, y, y_hi, z, n, c, bflag, v all 0; in_ready 0
//     while rst high, 1 the first cycle after release. Reset mid-EXEC or in DONE
//     aborts; no result is ever presented for an aborted op.
//   - Undefined op codes: none (3-bit op fully decoded).
// TESTING (WIDTH=8)
//   1 ADD a=10 b=3 -> next cycle out_valid=1, y=13, z=n=c=bflag=v=0, y_hi=0.
//   2 SUB a=3 b=10 -> y=249, n=1, bflag=1, c=0, v=0; SUB 5-5 -> y=0, z=1.
//   3 ADD 127+1 -> y=128,n=1,v=1,c=0; ADD 200+100 -> y=44,c=1,v=0;
//     SHL 0x81 by 1 -> y=0x02,c=1; SHR 0x81 by 9 -> y=0,z=1,c=0.
//   4 MUL 200*100 -> y_hi=0x4E, y=0x20, out_valid exactly 9 cycles after accept,
//     in_ready=0 for all 8 EXEC cycles; MUL 0*255 -> z=1.
//   5 AND 12&5 with out_ready=0 for 3 cycles -> y=4 held, in_ready=0; release
//     out_ready with OR 12|5 pending -> accepted same cycle, next cycle y=13.
//   6 rst=1 for 1 cycle at EXEC cycle 4 of a MUL -> all outputs 0, out_valid never
//     rises for that op; in_ready=1 cycle after rst release; new ADD completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// Registered 8-op ALU with valid/ready handshakes; MUL runs a WIDTH-cycle
// shift-add loop producing a double-width unsigned product on {y_hi, y}.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             bflag,
    output logic             v
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
    } op_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ma, mh, ml;
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] mh_n, ml_n;
    logic             accept;

    logic [WIDTH-1:0] r_y;
    logic             r_c, r_b, r_v;

    assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_comb begin
        r_y = '0;
        r_c = 1'b0;
        r_b = 1'b0;
        r_v = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                {r_c, r_y} = {1'b0, a} + {1'b0, b};
                r_v = (a[WIDTH-1] == b[WIDTH-1]) && (r_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r_y = a - b;
                r_b = (a < b);
                r_v = (a[WIDTH-1] != b[WIDTH-1]) && (r_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r_y = a & b;
            OP_OR:  r_y = a | b;
            OP_XOR: r_y = a ^ b;
            // One extra bit beyond the operand captures the last bit shifted out.
            OP_SHL: {r_c, r_y} = {1'b0, a} << b;
            OP_SHR: {r_y, r_c} = {a, 1'b0} >> b;
            default: ;
        endcase
    end

    // Right-shifting {mh, ml}: ml starts as b, so ml[0] is the current multiplier bit.
    always_comb begin
        msum = {1'b0, mh} + (ml[0] ? {1'b0, ma} : '0);
        mh_n = msum[WIDTH:1];
        ml_n = {msum[0], ml[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ma    <= '0;
            mh    <= '0;
            ml    <= '0;
            y     <= '0;
            y_hi  <= '0;
            z     <= 1'b0;
            n     <= 1'b0;
            c     <= 1'b0;
            bflag <= 1'b0;
            v     <= 1'b0;
        end else if (accept) begin
            if (op_t'(op) == OP_MUL) begin
                state <= EXEC;
                cnt   <= '0;
                ma    <= a;
                mh    <= '0;
                ml    <= b;
            end else begin
                state <= DONE;
                y     <= r_y;
                y_hi  <= '0;
                z     <= (r_y == '0);
                n     <= r_y[WIDTH-1];
                c     <= r_c;
                bflag <= r_b;
                v     <= r_v;
            end
        end else begin
            case (state)
                EXEC: begin
                    mh  <= mh_n;
                    ml  <= ml_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        y     <= ml_n;
                        y_hi  <= mh_n;
                        z     <= ({mh_n, ml_n} == '0);
                        n     <= mh_n[WIDTH-1];
                        c     <= 1'b0;
                        bflag <= 1'b0;
                        v     <= 1'b0;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: ;
            endcase
        end
    end

endmodule
